// File: rtl/rx_gate_packer.sv
// rx_gate_packer
//   Packs decimated I/Q pairs into a 16-bit show-ahead FIFO while the radar
//   gate window is open. Each window starts with a HEADER word, then every
//   accepted strobe contributes I followed by Q on consecutive cycles.
//
// Ports:
//   clock, reset         master clock, asynchronous active-low reset
//   enable               allows a new gate window to open
//   gate_enable          radar gate window
//   strobe_in, i_in, q_in  sample-valid strobe and the I/Q pair
//   clear_status         synchronous clear of the sticky flags
//   rd_en                pop request from the reader
//   rd_data              head-of-FIFO word (0 when empty)
//   empty, full, used    FIFO occupancy
//   overrun              sticky: a write was dropped because the FIFO was full
//   strobe_err           sticky: a strobe arrived while Q was being written
//   sample_count         pairs captured in the current or last window

module rx_gate_packer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [15:0] HEADER     = 16'hA5A5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  gate_enable,
    input  logic                  strobe_in,
    input  logic [15:0]           i_in,
    input  logic [15:0]           q_in,
    input  logic                  clear_status,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  overrun,
    output logic                  strobe_err,
    output logic [15:0]           sample_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, WR_I, WR_Q} state_t;

    state_t      state;
    logic [15:0] i_lat;
    logic [15:0] q_lat;
    logic [15:0] count_inc;

    logic        wr_en;
    logic [15:0] wr_data;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_write;
    logic                  do_read;

    // Saturating increment of the per-window pair count.
    assign count_inc = (sample_count == 16'hFFFF) ? sample_count : sample_count + 16'd1;

    // FIFO write request: the word each state contributes this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        unique case (state)
            IDLE: begin
                if (gate_enable && enable) begin
                    wr_en   = 1'b1;
                    wr_data = HEADER;
                end
            end
            ARMED: begin
                if (gate_enable && strobe_in) begin
                    wr_en   = 1'b1;
                    wr_data = i_in;
                end
            end
            WR_I: begin
                wr_en   = 1'b1;
                wr_data = i_lat;
            end
            WR_Q: begin
                wr_en   = 1'b1;
                wr_data = q_lat;
            end
            default: ;
        endcase
    end

    // Gate FSM with the pair latches, pair counter and collision flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            i_lat        <= '0;
            q_lat        <= '0;
            sample_count <= '0;
            strobe_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gate_enable && enable) begin
                        sample_count <= '0;
                        if (strobe_in) begin
                            // Header occupies this cycle, so the pair is replayed from latches.
                            i_lat <= i_in;
                            q_lat <= q_in;
                            state <= WR_I;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (!gate_enable) begin
                        state <= IDLE;
                    end else if (strobe_in) begin
                        q_lat        <= q_in;
                        sample_count <= count_inc;
                        state        <= WR_Q;
                    end
                end
                WR_I: begin
                    sample_count <= count_inc;
                    state        <= WR_Q;
                end
                WR_Q: begin
                    state <= gate_enable ? ARMED : IDLE;
                end
                default: state <= IDLE;
            endcase

            // Set beats clear when both happen in the same cycle.
            if (state == WR_Q && strobe_in) begin
                strobe_err <= 1'b1;
            end else if (clear_status) begin
                strobe_err <= 1'b0;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign do_read  = rd_en && !empty;
    assign do_write = wr_en && (!full || rd_en);

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            used    <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            unique case ({do_write, do_read})
                2'b10:   used <= used + (DEPTH_LOG2 + 1)'(1);
                2'b01:   used <= used - (DEPTH_LOG2 + 1)'(1);
                default: ;
            endcase

            if (wr_en && full && !rd_en) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end
        end
    end

    assign empty   = (used == '0);
    assign full    = (used == DEPTH_W);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_rx_gate_packer.sv
// Self-checking bench for rx_gate_packer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the gate/pair/FIFO behaviour.

module tb_rx_gate_packer;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;
    localparam logic [15:0] HEADER     = 16'hA5A5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        gate_enable = 1'b0;
    logic        strobe_in = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic        clear_status = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        empty;
    logic        full;
    logic [DEPTH_LOG2:0] used;
    logic        overrun;
    logic        strobe_err;
    logic [15:0] sample_count;

    int n_checks = 0;
    int n_errors = 0;

    rx_gate_packer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .HEADER     (HEADER)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .gate_enable  (gate_enable),
        .strobe_in    (strobe_in),
        .i_in         (i_in),
        .q_in         (q_in),
        .clear_status (clear_status),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .used         (used),
        .overrun      (overrun),
        .strobe_err   (strobe_err),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Window is either closed or open; words owed by an accepted pair sit in
    // pend and drain one per cycle. The FIFO is a plain queue.
    logic [15:0] fq[$];
    logic [15:0] pend[$];
    bit          m_open;
    logic [15:0] m_cnt;
    bit          m_ovr;
    bit          m_serr;
    bit          m_wr;
    logic [15:0] m_w;
    bit          m_full_b;
    bit          m_ovr_set;
    bit          m_serr_set;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            fq.delete();
            pend.delete();
            m_open = 0;
            m_cnt  = '0;
            m_ovr  = 0;
            m_serr = 0;
        end else begin
            m_wr       = 0;
            m_w        = '0;
            m_ovr_set  = 0;
            m_serr_set = 0;
            if (pend.size() > 0) begin
                if (pend.size() == 2) m_cnt = sat_inc(m_cnt);          // I word of a pair
                if (pend.size() == 1 && strobe_in) m_serr_set = 1;      // Q word cycle
                m_w  = pend.pop_front();
                m_wr = 1;
                if (pend.size() == 0) m_open = gate_enable;
            end else if (m_open) begin
                if (!gate_enable) begin
                    m_open = 0;
                end else if (strobe_in) begin
                    m_w  = i_in;
                    m_wr = 1;
                    pend.push_back(q_in);
                    m_cnt = sat_inc(m_cnt);
                end
            end else if (gate_enable && enable) begin
                m_w    = HEADER;
                m_wr   = 1;
                m_cnt  = '0;
                m_open = 1;
                if (strobe_in) begin
                    pend.push_back(i_in);
                    pend.push_back(q_in);
                end
            end

            m_full_b = (fq.size() == DEPTH);
            if (rd_en && fq.size() > 0) void'(fq.pop_front());
            if (m_wr) begin
                if (m_full_b && !rd_en) m_ovr_set = 1;
                else fq.push_back(m_w);
            end

            if (clear_status) begin
                m_ovr  = 0;
                m_serr = 0;
            end
            if (m_ovr_set)  m_ovr  = 1;
            if (m_serr_set) m_serr = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("rd_data",      {16'd0, rd_data}, {16'd0, (fq.size() > 0) ? fq[0] : 16'd0});
        check("empty",        {31'd0, empty}, {31'd0, fq.size() == 0});
        check("full",         {31'd0, full}, {31'd0, fq.size() == DEPTH});
        check("used",         {27'd0, used}, fq.size());
        check("overrun",      {31'd0, overrun}, {31'd0, m_ovr});
        check("strobe_err",   {31'd0, strobe_err}, {31'd0, m_serr});
        check("sample_count", {16'd0, sample_count}, {16'd0, m_cnt});
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b0; gate_enable = 1'b0; strobe_in = 1'b0;
        i_in = '0; q_in = '0; clear_status = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic pulse_strobe(input logic [15:0] i, input logic [15:0] q);
        strobe_in = 1'b1; i_in = i; q_in = q;
        tick(1);
        strobe_in = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [15:0] w);
        check(name, {16'd0, rd_data}, {16'd0, w});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    logic [15:0] exp1 [7];

    initial begin
        exp1[0] = 16'hA5A5; exp1[1] = 16'h4000; exp1[2] = 16'hFFFF; exp1[3] = 16'h0000;
        exp1[4] = 16'h0000; exp1[5] = 16'h0001; exp1[6] = 16'h0002;

        do_reset();
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_used", {27'd0, used}, 32'd0);

        // Basic window, reader idle.
        enable = 1'b1; gate_enable = 1'b1;
        tick(1);
        check("hdr_visible", {16'd0, rd_data}, 32'h0000A5A5);
        tick(10);
        pulse_strobe(16'h4000, 16'hFFFF); tick(127);
        pulse_strobe(16'h0000, 16'h0000); tick(127);
        pulse_strobe(16'h0001, 16'h0002); tick(127);
        gate_enable = 1'b0;
        tick(3);
        check("basic_used", {27'd0, used}, 32'd7);
        check("basic_count", {16'd0, sample_count}, 32'd3);
        for (int k = 0; k < 7; k++) pop_expect("basic_word", exp1[k]);
        check("basic_drained", {31'd0, empty}, 32'd1);

        // Strobe on the gate-rise cycle.
        do_reset();
        enable = 1'b1; gate_enable = 1'b1;
        pulse_strobe(16'd7, 16'd9);
        check("rise_used1", {27'd0, used}, 32'd1);
        tick(1);
        check("rise_used2", {27'd0, used}, 32'd2);
        tick(1);
        check("rise_used3", {27'd0, used}, 32'd3);
        gate_enable = 1'b0;
        tick(2);
        check("rise_count", {16'd0, sample_count}, 32'd1);
        pop_expect("rise_hdr", HEADER);
        pop_expect("rise_i", 16'd7);
        pop_expect("rise_q", 16'd9);

        // Overflow and clear.
        do_reset();
        enable = 1'b1; gate_enable = 1'b1;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            pulse_strobe(16'(16'h100 + k), 16'(16'h200 + k));
            tick(3);
        end
        gate_enable = 1'b0;
        tick(2);
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_overrun", {31'd0, overrun}, 32'd1);
        check("ovf_used", {27'd0, used}, 32'd16);
        check("ovf_count", {16'd0, sample_count}, 32'd10);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        check("ovf_cleared", {31'd0, overrun}, 32'd0);

        // Full with simultaneous pop: reader keeps pace with each write.
        rd_en = 1'b1; gate_enable = 1'b1;
        tick(1);                                 // header write + pop
        for (int k = 0; k < 3; k++) begin
            pulse_strobe(16'(16'h300 + k), 16'(16'h400 + k));
            tick(1);                             // Q write + pop
            check("fullpop_used", {27'd0, used}, 32'd16);
            rd_en = 1'b0;
            tick(2);
            rd_en = 1'b1;
        end
        rd_en = 1'b0;
        check("fullpop_overrun", {31'd0, overrun}, 32'd0);
        gate_enable = 1'b0;
        tick(2);

        // Strobe collision.
        do_reset();
        enable = 1'b1; gate_enable = 1'b1;
        tick(1);
        pulse_strobe(16'd1, 16'd2);
        pulse_strobe(16'd3, 16'd4);
        tick(1);
        check("coll_err", {31'd0, strobe_err}, 32'd1);
        check("coll_used", {27'd0, used}, 32'd3);
        check("coll_count", {16'd0, sample_count}, 32'd1);
        gate_enable = 1'b0;
        tick(2);

        // Gated off: strobes with gate low, and a gate rise while disabled.
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin pulse_strobe(16'(k), 16'(k)); tick(1); end
        enable = 1'b0; gate_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin pulse_strobe(16'(k), 16'(k)); tick(1); end
        check("gated_empty", {31'd0, empty}, 32'd1);
        gate_enable = 1'b0;
        tick(1);

        // Reset mid-window with words held and a flag set.
        enable = 1'b1; gate_enable = 1'b1;
        tick(1);
        pulse_strobe(16'h55, 16'h66);
        pulse_strobe(16'h77, 16'h88);
        tick(1);
        reset = 1'b0;
        #1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_used", {27'd0, used}, 32'd0);
        check("rst_err", {31'd0, strobe_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_count", {16'd0, sample_count}, 32'd0);
        idle_inputs();
        tick(2);
        reset = 1'b1;
        tick(1);

        // Randomized traffic against the model.
        enable = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(39) == 0) gate_enable = ~gate_enable;
            if ($urandom_range(19) == 0) enable = ~enable;
            strobe_in    = ($urandom_range(2) == 0);
            i_in         = 16'($urandom);
            q_in         = 16'($urandom);
            rd_en        = ($urandom_range(99) < 40);
            clear_status = ($urandom_range(49) == 0);
            if ($urandom_range(1499) == 0) begin
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end
            tick(1);
        end
        idle_inputs();
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_gate_packer.md
Name: rx_gate_packer

Overview:
- Downstream of halfband_decim in the receive chain.
- Takes the decimated I/Q pair on each output strobe, but only while the radar gate window is open.
- Frames each gate window with a header word, then serialises samples as I then Q into a 16-bit FIFO.
- The FIFO is drained by the USB-side reader in the same clock domain; also reports overrun, strobe collisions and the per-gate sample-pair count.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 16-bit words (default 16 words).
- HEADER, 16'hA5A5, word written at the start of each gate window.

Ports:
- clock  input  1  master receive clock (64 MHz).
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  global enable; when 0 no new gate window may open.
- gate_enable  input  1  radar gate window, synchronous to clock.
- strobe_in  input  1  one-cycle sample-valid from halfband_decim strobe_out.
- i_in  input  16  I sample, valid with strobe_in.
- q_in  input  16  Q sample, valid with strobe_in.
- clear_status  input  1  synchronous clear of overrun and strobe_err.
- rd_en  input  1  pop request from reader.
- rd_data  output  16  head-of-FIFO word (show-ahead).
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- used  output  DEPTH_LOG2+1  words currently held.
- overrun  output  1  sticky; set when a write is dropped because the FIFO is full.
- strobe_err  output  1  sticky; set when a strobe arrives during WR_Q.
- sample_count  output  16  pairs captured in the current or last gate window.

Behaviour:
- Reset values: FIFO pointers 0, empty=1, full=0, used=0, rd_data=0, overrun=0, strobe_err=0, sample_count=0, state IDLE. Reset asserted mid-operation aborts any pending pair and discards FIFO contents.
- gate_rise means gate_enable=1 while in IDLE. A window opens only if enable=1.
- States:
  - IDLE:
    - On gate_rise && enable: write HEADER and clear sample_count to 0.
    - If strobe_in is also high that cycle: latch I/Q and go to WR_I. Otherwise go to ARMED.
    - Strobes in IDLE are otherwise ignored.
  - ARMED:
    - gate_enable=0: go to IDLE.
    - Else, on strobe_in: write i_in, latch q_in, increment sample_count, go to WR_Q.
  - WR_I: write latched I, increment sample_count, go to WR_Q.
  - WR_Q:
    - Write latched Q.
    - If strobe_in is high this cycle: set strobe_err and drop that sample.
    - Next state: ARMED if gate_enable=1, else IDLE.
- A gate fall during WR_I or WR_Q still completes the pair. No partial pairs are ever written unless a word is dropped because the FIFO is full.
- sample_count saturates at 16'hFFFF. It holds its value after the gate closes until the next gate_rise.
- FIFO:
  - Circular buffer, pointers DEPTH_LOG2 bits wide with wrap-around.
  - rd_data shows the head word whenever empty=0.
  - rd_en with empty=1 is ignored.
  - A write landing while full=1 and rd_en=0 is dropped and sets overrun.
  - A write with full=1 and rd_en=1 in the same cycle succeeds; used is unchanged.
  - A simultaneous read and write when empty: the write succeeds and the read is ignored.
- Latency: strobe_in in ARMED at cycle t gives empty=0 with rd_data=I at t+1; Q is written at t+2. The header is visible the cycle after gate_rise.
- Sticky flags: clear_status clears overrun and strobe_err. If a set event occurs in the same cycle as clear_status, the set wins.
- Writes are 16-bit two's complement, passed through unmodified. No arithmetic is performed on samples.

Test Plan:
- Basic window, reader idle:
  - Stimulus: reset, gate high, three strobes 128 clocks apart with I=16384,Q=-1 then I=0,Q=0 then I=1,Q=2; gate low.
  - Response: FIFO holds A5A5,4000,FFFF,0000,0000,0001,0002; used=7; sample_count=3.
- Strobe on gate-rise cycle:
  - Stimulus: gate rises together with a strobe carrying I=7, Q=9.
  - Response: HEADER, then 7, then 9 written on consecutive cycles; sample_count=1.
- Overflow and clear:
  - Stimulus: DEPTH=16, reader idle, 10 strobes in one gate.
  - Response: first 16 words kept (HEADER plus 7.5 pairs); overrun=1 and full=1; a later clear_status pulse gives overrun=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, rd_en held high during further strobes.
  - Response: no overrun; used stays 16; words pop out in order.
- Strobe collision:
  - Stimulus: strobe at t, then a second strobe at t+1 (lands in WR_Q).
  - Response: strobe_err=1; the second sample is absent from the FIFO.
- Gated off and async reset:
  - Stimulus: strobes with gate low, and strobes with enable=0 at gate rise.
  - Response: nothing written.
  - Stimulus: reset pulse mid-window with FIFO holding words.
  - Response: empty=1, used=0, all flags 0.
